// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
//   Writeback scheduler and long-latency scoreboard for the 32x32 register
//   file (one write port, r0 hard-wired to zero).
//   - Arbitrates the single write port between requester A (short ALU path)
//     and requester B (long-latency return path). A normally wins. B gets
//     forced priority once it has waited STARVE_LIMIT cycles.
//   - Tracks registers with a long-latency write in flight. Decode is stalled
//     on RAW/WAW hazards against those registers.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   issue_*                decode instruction (valid, long, rs1, rs2, rd)
//   stall                  decode must hold; instruction not accepted
//   a_valid/a_sel/a_dat    requester A writeback request; a_ready = accepted
//   b_valid/b_sel/b_dat    requester B writeback request; b_ready = accepted
//   rf_wen/rf_wsel/rf_wdat registered register-file write port
//   pend_cnt               number of busy registers (registered)
module rf_wb_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DW           = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          issue_valid,
    input  logic          issue_long,
    input  logic [4:0]    issue_rs1,
    input  logic [4:0]    issue_rs2,
    input  logic [4:0]    issue_rd,
    output logic          stall,
    input  logic          a_valid,
    input  logic [4:0]    a_sel,
    input  logic [DW-1:0] a_dat,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [4:0]    b_sel,
    input  logic [DW-1:0] b_dat,
    output logic          b_ready,
    output logic          rf_wen,
    output logic [4:0]    rf_wsel,
    output logic [DW-1:0] rf_wdat,
    output logic [5:0]    pend_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Bit 0 is kept at zero so a select of r0 can never raise a hazard.
    logic [31:0]   busy;
    logic [31:0]   busy_nxt;
    logic [5:0]    pend_nxt;
    logic [3:0]    b_wait;
    logic          wb_from_b;
    logic          grant_a;
    logic          grant_b;
    logic          issue_set;
    logic [4:0]    win_sel;
    logic [DW-1:0] win_dat;

    always_comb begin
        stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);
    end

    always_comb begin
        grant_b = b_valid & (~a_valid | (b_wait >= LIMIT));
        grant_a = a_valid & ~grant_b;
        a_ready = grant_a;
        b_ready = grant_b;
        win_sel = grant_b ? b_sel : a_sel;
        win_dat = grant_b ? b_dat : a_dat;
    end

    // Clear is applied before set so that a same-edge set of the same
    // register wins.
    always_comb begin
        issue_set = issue_valid & ~stall & issue_long & (issue_rd != 5'd0);
        busy_nxt  = busy;
        if (rf_wen && wb_from_b) begin
            busy_nxt[rf_wsel] = 1'b0;
        end
        if (issue_set) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // pend_cnt is registered from the next busy vector so it moves on the
    // same edge as the scoreboard itself.
    always_comb begin
        pend_nxt = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            pend_nxt = pend_nxt + 6'(busy_nxt[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy      <= '0;
            pend_cnt  <= '0;
            b_wait    <= '0;
            rf_wen    <= 1'b0;
            rf_wsel   <= '0;
            rf_wdat   <= '0;
            wb_from_b <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= pend_nxt;

            if (b_valid && !grant_b) begin
                if (b_wait != 4'hF) begin
                    b_wait <= b_wait + 4'd1;
                end
            end else begin
                b_wait <= '0;
            end

            // A grant to r0 is consumed but produces no write.
            rf_wen    <= 1'b0;
            wb_from_b <= grant_b;
            if ((grant_a || grant_b) && win_sel != 5'd0) begin
                rf_wen  <= 1'b1;
                rf_wsel <= win_sel;
                rf_wdat <= win_dat;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

    localparam int STARVE = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        stall;
    logic        a_valid, b_valid;
    logic [4:0]  a_sel, b_sel;
    logic [31:0] a_dat, b_dat;
    logic        a_ready, b_ready;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [5:0]  pend_cnt;

    rf_wb_scheduler #(.STARVE_LIMIT(STARVE), .DW(32)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .stall(stall),
        .a_valid(a_valid), .a_sel(a_sel), .a_dat(a_dat), .a_ready(a_ready),
        .b_valid(b_valid), .b_sel(b_sel), .b_dat(b_dat), .b_ready(b_ready),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .pend_cnt(pend_cnt)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model: a set of in-flight long destinations, a wait counter
    // for B, and the last write the port performed.
    bit          m_busy[32];
    int          m_bwait;
    bit          m_wen, m_fromb;
    int          m_wsel;
    logic [31:0] m_wdat;
    bit          hold_a, hold_b;

    function automatic int busy_count();
        int n = 0;
        foreach (m_busy[i]) if (i != 0 && m_busy[i]) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_long = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        a_valid = 0; a_sel = 0; a_dat = 0;
        b_valid = 0; b_sel = 0; b_dat = 0;
    endtask

    // One clock cycle: let inputs settle, compare against the model, advance
    // the model with the spec rules, then step past the edge.
    task automatic cyc();
        bit st, ga, gb;
        int sel;
        #1;
        st = issue_valid && ((issue_rs1 != 0 && m_busy[issue_rs1]) ||
                             (issue_rs2 != 0 && m_busy[issue_rs2]) ||
                             (issue_rd  != 0 && m_busy[issue_rd]));
        gb = b_valid && (!a_valid || m_bwait >= STARVE);
        ga = a_valid && !gb;
        if (chk_en) begin
            chk("stall", stall, st);
            chk("a_ready", a_ready, ga);
            chk("b_ready", b_ready, gb);
            chk("rf_wen", rf_wen, m_wen);
            chk("pend_cnt", pend_cnt, busy_count());
            if (m_wen) begin
                chk("rf_wsel", rf_wsel, m_wsel);
                chk("rf_wdat", rf_wdat, m_wdat);
            end
        end
        if (RST) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_bwait = 0; m_wen = 0; m_fromb = 0; m_wsel = 0; m_wdat = 0;
            hold_a = 0; hold_b = 0;
        end else begin
            if (m_wen && m_fromb) m_busy[m_wsel] = 0;
            if (issue_valid && !st && issue_long && issue_rd != 0) m_busy[issue_rd] = 1;
            m_bwait = (b_valid && !gb) ? ((m_bwait < 15) ? m_bwait + 1 : 15) : 0;
            if (ga || gb) begin
                sel = gb ? int'(b_sel) : int'(a_sel);
                m_fromb = gb;
                m_wen = (sel != 0);
                if (m_wen) begin
                    m_wsel = sel;
                    m_wdat = gb ? b_dat : a_dat;
                end
            end else begin
                m_wen = 0;
            end
            hold_a = a_valid && !ga;
            hold_b = b_valid && !gb;
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        int busy_list[$];
        idle();

        // Reset held for two cycles with both requesters active.
        RST = 1;
        a_valid = 1; a_sel = 5'd3; a_dat = 32'hA1A1_0001;
        b_valid = 1; b_sel = 5'd4; b_dat = 32'hB1B1_0001;
        cyc();
        chk_en = 1;
        issue_valid = 1; issue_rs1 = 5'd3; issue_rs2 = 5'd4; issue_rd = 5'd5;
        cyc();
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_pend", pend_cnt, 6'd0);
        RST = 0;
        issue_valid = 0;
        cyc();
        chk("rst_first_wen", rf_wen, 1'b1);
        chk("rst_first_wdat", rf_wdat, 32'hA1A1_0001);

        // Long issue to r5 followed by a RAW read of r5.
        idle();
        cyc();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd5;
        cyc();
        issue_long = 0; issue_rd = 0; issue_rs1 = 5'd5;
        #1;
        chk("raw_stall", stall, 1'b1);
        chk("raw_pend", pend_cnt, 6'd1);
        cyc();
        b_valid = 1; b_sel = 5'd5; b_dat = 32'hDEADBEEF;
        cyc();
        b_valid = 0;
        chk("raw_wen", rf_wen, 1'b1);
        chk("raw_wsel", rf_wsel, 5'd5);
        chk("raw_wdat", rf_wdat, 32'hDEADBEEF);
        cyc();
        #1;
        chk("raw_release", stall, 1'b0);
        chk("raw_pend0", pend_cnt, 6'd0);
        cyc();

        // r0 is never tracked and never hazards.
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = 0;
        cyc();
        chk("r0_pend", pend_cnt, 6'd0);
        issue_long = 0;
        #1;
        chk("r0_stall", stall, 1'b0);
        cyc();
        idle();
        a_valid = 1; a_sel = 0; a_dat = 32'h1234_5678;
        #1;
        chk("r0_a_ready", a_ready, 1'b1);
        cyc();
        a_valid = 0;
        chk("r0_wen", rf_wen, 1'b0);
        cyc();

        // Contention: A wins STARVE cycles, then B is forced through.
        idle();
        a_valid = 1; a_sel = 5'd9;  a_dat = 32'h0000_0A09;
        b_valid = 1; b_sel = 5'd10; b_dat = 32'h0000_0B10;
        for (int k = 0; k < STARVE; k++) begin
            #1;
            chk("starve_a_win", a_ready, 1'b1);
            cyc();
            a_dat = a_dat + 1;
        end
        #1;
        chk("starve_b_forced", b_ready, 1'b1);
        chk("starve_a_held", a_ready, 1'b0);
        cyc();
        b_valid = 0;
        #1;
        chk("starve_a_again", a_ready, 1'b1);
        cyc();

        // WAW on r7: reissue stalls until the B write commits.
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd7;
        cyc();
        chk("waw_pend1", pend_cnt, 6'd1);
        #1;
        chk("waw_stall", stall, 1'b1);
        b_valid = 1; b_sel = 5'd7; b_dat = 32'h7777_0007;
        cyc();
        b_valid = 0;
        cyc();
        #1;
        chk("waw_pend0", pend_cnt, 6'd0);
        chk("waw_accept", stall, 1'b0);
        cyc();
        chk("waw_pend_again", pend_cnt, 6'd1);
        idle();
        b_valid = 1; b_sel = 5'd7; b_dat = 32'h7777_0008;
        cyc();
        b_valid = 0;
        cyc();
        cyc();

        // Several pending writes returned out of order.
        idle();
        issue_valid = 1; issue_long = 1;
        for (int r = 1; r <= 3; r++) begin
            issue_rd = 5'(r);
            cyc();
        end
        chk("multi_pend3", pend_cnt, 6'd3);
        issue_long = 0; issue_rd = 0; issue_rs1 = 5'd2;
        foreach (busy_list[i]) busy_list.delete(i);
        busy_list = '{3, 1, 2};
        for (int k = 0; k < 3; k++) begin
            b_valid = 1; b_sel = 5'(busy_list[k]); b_dat = 32'hC0DE_0000 + 32'(k);
            cyc();
            b_valid = 0;
            cyc();
            chk("multi_pend_step", pend_cnt, 6'(2 - k));
        end
        #1;
        chk("multi_r2_free", stall, 1'b0);
        cyc();

        // Randomized traffic against the model, with occasional reset.
        idle();
        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom_range(0, 199) == 0);
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_long  = ($urandom_range(0, 2) == 0);
            issue_rs1 = pick_reg(); issue_rs2 = pick_reg(); issue_rd = pick_reg();
            if (!hold_a) begin
                a_valid = ($urandom_range(0, 1) == 1);
                a_sel = pick_reg(); a_dat = $urandom();
            end
            if (!hold_b) begin
                busy_list.delete();
                foreach (m_busy[i]) if (m_busy[i]) busy_list.push_back(i);
                if (busy_list.size() > 0 && $urandom_range(0, 9) < 5) begin
                    b_valid = 1;
                    b_sel = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
                end else begin
                    b_valid = ($urandom_range(0, 9) == 0);
                    b_sel = pick_reg();
                end
                b_dat = $urandom();
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
